// File: rtl/aes_spi_frame_slave_if.sv
// Bus between the SPI frame slave and its environment: the SPI pins, the
// assembled block/key handed to the AES core, and the core result path.
interface aes_spi_frame_slave_if #(
  parameter int DATA_BYTES = 16
);
  logic                    cs;
  logic                    sclk;
  logic                    mosi;
  logic                    miso;
  logic                    byte_done;
  logic [DATA_BYTES*8-1:0] blk_data;
  logic [255:0]            blk_key;
  logic [7:0]              blk_key_size;
  logic                    blk_valid;
  logic [DATA_BYTES*8-1:0] core_result;
  logic                    core_done;
  logic                    err;

  modport slave (
    input  cs, sclk, mosi, core_result, core_done,
    output miso, byte_done, blk_data, blk_key, blk_key_size, blk_valid, err
  );

  modport master (
    output cs, sclk, mosi, core_result, core_done,
    input  miso, byte_done, blk_data, blk_key, blk_key_size, blk_valid, err
  );
endinterface

// File: rtl/aes_spi_frame_slave.sv
// SPI mode-0 slave front-end for the AES cores. Receives data block, key-size
// byte and key; hands them to the core; returns the core result on miso.
// Optional inactivity timeout: define AES_SPI_TIMEOUT_EN.
module aes_spi_frame_slave #(
  parameter int DATA_BYTES     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  reset,
  aes_spi_frame_slave_if.slave spi
);

  localparam int DW  = DATA_BYTES * 8;
  localparam int BIW = $clog2(DATA_BYTES);

  typedef enum logic [2:0] {RX_DATA, RX_KSIZE, RX_KEY, WAIT_CORE, TX_RESULT} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk_s, w_cs_s, w_mosi_s, w_sclk_rise, w_sclk_fall;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [7:0]             r_rx_byte;
  logic                   r_byte_stb;
  state_t                 r_state, w_state_nxt;
  logic [5:0]             r_byte_cnt, w_byte_cnt_nxt;
  logic                   w_byte_done_nxt, w_blk_valid_nxt, w_err_set, w_cnt_clr;
  logic                   w_store_data, w_store_ksize, w_store_key;
  logic                   w_load_first, w_load_next, w_tx_clear, w_timeout;
  logic [DW-1:0]          r_blk_data, r_tx_buf;
  logic [255:0]           r_blk_key;
  logic [7:0]             r_blk_key_size, r_tx_shift, w_tx_next;
  logic                   r_miso, r_byte_done, r_blk_valid, r_err;
  logic [BIW+2:0]         w_data_lsb, w_tx_lsb;
  logic [7:0]             w_key_lsb;

  // Bring the asynchronous SPI pins into the clk domain; cs idles high.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values, regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      r_sclk_prev <= w_sclk_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_prev & ~w_cs_s;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_prev & ~w_cs_s;

  // Shift in mosi on rising edges; flag a complete byte one clk later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_byte_stb <= 1'b0;
    end else begin
      r_byte_stb <= 1'b0;
      if (w_cs_s || w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_byte  <= {r_rx_shift, w_mosi_s};
          r_byte_stb <= 1'b1;
        end
      end
    end
  end

`ifdef AES_SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_to_active, w_sclk_edge;

  assign w_sclk_edge = w_sclk_s ^ r_sclk_prev;
  assign w_to_active = !((r_state == RX_DATA) && (r_byte_cnt == '0)) && (r_state != WAIT_CORE);
  assign w_timeout   = (r_to_cnt == TW'(TIMEOUT_CYCLES));

  // Count clks without sclk activity while a frame is in progress.
  always_ff @(posedge clk) begin
    if (reset || w_timeout || w_sclk_edge || !w_to_active) r_to_cnt <= '0;
    else                                                   r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  // Feature compiled out: a stalled frame waits indefinitely.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Frame state and byte position within the current section.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RX_DATA;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  // Next-state decode and datapath strobes for each completed byte.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_byte_done_nxt = 1'b0;
    w_blk_valid_nxt = 1'b0;
    w_err_set       = 1'b0;
    w_cnt_clr       = 1'b0;
    w_store_data    = 1'b0;
    w_store_ksize   = 1'b0;
    w_store_key     = 1'b0;
    w_load_first    = 1'b0;
    w_load_next     = 1'b0;
    w_tx_clear      = 1'b0;
    if (w_timeout) begin
      w_err_set      = 1'b1;
      w_cnt_clr      = 1'b1;
      w_tx_clear     = 1'b1;
      w_byte_cnt_nxt = '0;
      w_state_nxt    = RX_DATA;
    end else begin
      case (r_state)
        RX_DATA: if (r_byte_stb) begin
          w_byte_done_nxt = 1'b1;
          w_store_data    = 1'b1;
          if (r_byte_cnt == 6'(DATA_BYTES - 1)) begin
            w_byte_cnt_nxt = '0;
            w_state_nxt    = RX_KSIZE;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 6'd1;
          end
        end
        RX_KSIZE: if (r_byte_stb) begin
          w_byte_done_nxt = 1'b1;
          if (r_rx_byte inside {8'd16, 8'd24, 8'd32}) begin
            w_store_ksize = 1'b1;
            w_state_nxt   = RX_KEY;
          end else begin
            w_err_set   = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = RX_DATA;
          end
          w_byte_cnt_nxt = '0;
        end
        RX_KEY: if (r_byte_stb) begin
          w_byte_done_nxt = 1'b1;
          w_store_key     = 1'b1;
          if ({2'b00, r_byte_cnt} == r_blk_key_size - 8'd1) begin
            w_blk_valid_nxt = 1'b1;
            w_byte_cnt_nxt  = '0;
            w_state_nxt     = WAIT_CORE;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 6'd1;
          end
        end
        WAIT_CORE: if (spi.core_done) begin
          w_load_first    = 1'b1;
          w_byte_done_nxt = 1'b1;
          w_byte_cnt_nxt  = '0;
          w_state_nxt     = TX_RESULT;
        end
        TX_RESULT: if (r_byte_stb) begin
          w_byte_done_nxt = 1'b1;
          if (r_byte_cnt == 6'(DATA_BYTES - 1)) begin
            w_tx_clear     = 1'b1;
            w_byte_cnt_nxt = '0;
            w_state_nxt    = RX_DATA;
          end else begin
            w_load_next    = 1'b1;
            w_byte_cnt_nxt = r_byte_cnt + 6'd1;
          end
        end
        default: w_state_nxt = RX_DATA;
      endcase
    end
  end

  assign w_data_lsb = {BIW'(DATA_BYTES - 1) - r_byte_cnt[BIW-1:0], 3'b000};
  assign w_tx_lsb   = {BIW'(DATA_BYTES - 1) - (r_byte_cnt[BIW-1:0] + BIW'(1)), 3'b000};
  assign w_key_lsb  = {5'd31 - r_byte_cnt[4:0], 3'b000};
  assign w_tx_next  = r_tx_buf[w_tx_lsb +: 8];

  // Block/key assembly, result shifting on miso, handshake pulses and err.
  // NOTE: the block and key registers are reset explicitly because their
  // zero state is visible on the outputs, not merely internal storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk_data     <= '0;
      r_blk_key      <= '0;
      r_blk_key_size <= '0;
      r_tx_buf       <= '0;
      r_tx_shift     <= '0;
      r_miso         <= 1'b0;
      r_byte_done    <= 1'b0;
      r_blk_valid    <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_byte_done <= w_byte_done_nxt;
      r_blk_valid <= w_blk_valid_nxt;
      if (w_err_set)     r_err <= 1'b1;
      if (w_store_data)  r_blk_data[w_data_lsb +: 8] <= r_rx_byte;
      if (w_store_ksize) begin
        r_blk_key_size <= r_rx_byte;
        r_blk_key      <= '0;
      end
      if (w_store_key)   r_blk_key[w_key_lsb +: 8] <= r_rx_byte;
      if (w_tx_clear) begin
        r_tx_shift <= '0;
        r_miso     <= 1'b0;
      end else if (w_load_first) begin
        r_tx_buf   <= spi.core_result;
        r_tx_shift <= spi.core_result[DW-1 -: 8];
        r_miso     <= spi.core_result[DW-1];
      end else if (w_load_next) begin
        r_tx_shift <= w_tx_next;
        r_miso     <= w_tx_next[7];
      end else if (w_sclk_fall && (r_state == TX_RESULT) && (r_bit_cnt != 3'd0)) begin
        // The falling edge after bit 8 is skipped so the next byte's MSB stays put.
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        r_miso     <= r_tx_shift[6];
      end
    end
  end

  assign spi.miso         = r_miso;
  assign spi.byte_done    = r_byte_done;
  assign spi.blk_valid    = r_blk_valid;
  assign spi.blk_data     = r_blk_data;
  assign spi.blk_key      = r_blk_key;
  assign spi.blk_key_size = r_blk_key_size;
  assign spi.err          = r_err;

endmodule
